// File: rtl/lsu_pkg.sv
// Shared load/store unit definitions: access sizes, store FSM states,
// the memory beat payload, and the load-side extraction helper.
package lsu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NBYTES = XLEN / 8;
  localparam int unsigned OFF_W  = 2;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BEAT0 = 2'b01,
    ST_BEAT1 = 2'b10
  } store_state_e;

  typedef struct packed {
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
    logic [NBYTES-1:0] bmask;
  } mem_beat_t;

  typedef enum logic {
    LOAD_ZEXT = 1'b0,
    LOAD_SEXT = 1'b1
  } load_ext_e;

  // Pull a byte/halfword/word out of a loaded word and extend it to XLEN.
  function automatic logic [XLEN-1:0] load_extract(
    input logic [XLEN-1:0]  word,
    input logic [OFF_W-1:0] off,
    input size_e            size,
    input load_ext_e        ext
  );
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] result;
    shifted = word >> {off, 3'b000};
    case (size)
      SIZE_BYTE: result = (ext == LOAD_SEXT) ? {{24{shifted[7]}}, shifted[7:0]}
                                             : {24'h0, shifted[7:0]};
      SIZE_HALF: result = (ext == LOAD_SEXT) ? {{16{shifted[15]}}, shifted[15:0]}
                                             : {16'h0, shifted[15:0]};
      default:   result = shifted;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/store_lane_shift.sv
// Combinational lane placement for stores: builds the byte mask and shifted
// write data for either beat, and flags accesses that straddle a word.
module store_lane_shift
  import lsu_pkg::*;
(
  input  logic [OFF_W-1:0]  off,
  input  size_e             size,
  input  logic [XLEN-1:0]   data,
  input  logic              beat,
  output logic [NBYTES-1:0] mask,
  output logic [XLEN-1:0]   wdata,
  output logic              split
);

  logic [NBYTES-1:0]   base_mask;
  logic [XLEN-1:0]     data_trim;
  logic [2*NBYTES-1:0] mask_wide;
  logic [2*XLEN-1:0]   data_wide;

  // Place the access across a two-word window; anything landing in the upper
  // word belongs to the second beat.
  always_comb begin
    base_mask = 4'b1111;
    data_trim = data;
    case (size)
      SIZE_BYTE: begin
        base_mask = 4'b0001;
        data_trim = {24'h0, data[7:0]};
      end
      SIZE_HALF: begin
        base_mask = 4'b0011;
        data_trim = {16'h0, data[15:0]};
      end
      default: begin
        base_mask = 4'b1111;
        data_trim = data;
      end
    endcase
    mask_wide = 8'(base_mask) << off;
    data_wide = 64'(data_trim) << {off, 3'b000};
    split     = |mask_wide[2*NBYTES-1:NBYTES];
    if (beat) begin
      mask  = mask_wide[2*NBYTES-1:NBYTES];
      wdata = data_wide[2*XLEN-1:XLEN];
    end else begin
      mask  = mask_wide[NBYTES-1:0];
      wdata = data_wide[XLEN-1:0];
    end
  end

endmodule

// File: rtl/store_align.sv
// Store aligner: turns byte-addressed stores into word-aligned memory beats,
// splitting word-straddling stores in two or rejecting them.
module store_align
  import lsu_pkg::*;
#(
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [XLEN-1:0]   i_addr,
  input  logic [XLEN-1:0]   i_data,
  input  logic [1:0]        i_size,
  output logic              o_mem_valid,
  input  logic              i_mem_ready,
  output logic [XLEN-1:0]   o_mem_addr,
  output logic [XLEN-1:0]   o_mem_wdata,
  output logic [NBYTES-1:0] o_mem_bmask,
  output logic              o_err
);

  store_state_e      state_q, state_d;
  logic [OFF_W-1:0]  off_q, off_d;
  size_e             size_q, size_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic              split_q, split_d;
  mem_beat_t         beat_q, beat_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              ready_q, ready_d;

  logic [OFF_W-1:0]  sh_off;
  size_e             sh_size;
  logic [XLEN-1:0]   sh_data;
  logic              sh_beat;
  logic [NBYTES-1:0] sh_mask;
  logic [XLEN-1:0]   sh_wdata;
  logic              sh_split;

  // In IDLE the shifter looks at the incoming request (first beat); otherwise
  // it looks at the captured request (second beat).
  always_comb begin
    if (state_q == ST_IDLE) begin
      sh_off  = i_addr[OFF_W-1:0];
      sh_size = size_e'(i_size);
      sh_data = i_data;
      sh_beat = 1'b0;
    end else begin
      sh_off  = off_q;
      sh_size = size_q;
      sh_data = data_q;
      sh_beat = 1'b1;
    end
  end

  store_lane_shift u_lane_shift (
    .off   (sh_off),
    .size  (sh_size),
    .data  (sh_data),
    .beat  (sh_beat),
    .mask  (sh_mask),
    .wdata (sh_wdata),
    .split (sh_split)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    size_d  = size_q;
    data_d  = data_q;
    split_d = split_q;
    beat_d  = beat_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_req_valid) begin
          off_d   = i_addr[OFF_W-1:0];
          size_d  = size_e'(i_size);
          data_d  = i_data;
          split_d = sh_split;
          if (sh_split && !SPLIT_EN) begin
            err_d = 1'b1;
          end else begin
            state_d      = ST_BEAT0;
            valid_d      = 1'b1;
            beat_d.addr  = {i_addr[XLEN-1:OFF_W], 2'b00};
            beat_d.wdata = sh_wdata;
            beat_d.bmask = sh_mask;
          end
        end
      end
      ST_BEAT0: begin
        if (i_mem_ready) begin
          if (split_q) begin
            state_d      = ST_BEAT1;
            beat_d.addr  = beat_q.addr + 32'd4;
            beat_d.wdata = sh_wdata;
            beat_d.bmask = sh_mask;
          end else begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            beat_d  = '0;
          end
        end
      end
      ST_BEAT1: begin
        if (i_mem_ready) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          beat_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        beat_d  = '0;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      off_q   <= '0;
      size_q  <= SIZE_BYTE;
      data_q  <= '0;
      split_q <= 1'b0;
      beat_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      size_q  <= size_d;
      data_q  <= data_d;
      split_q <= split_d;
      beat_q  <= beat_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  assign o_req_ready = ready_q;
  assign o_mem_valid = valid_q;
  assign o_mem_addr  = beat_q.addr;
  assign o_mem_wdata = beat_q.wdata;
  assign o_mem_bmask = beat_q.bmask;
  assign o_err       = err_q;

endmodule

// File: tb/tb_store_align.sv
// Bench for store_align: a byte-walking reference model predicts the beats
// of every request, and one compare process checks both instances each cycle.
module tb_store_align;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid [2];
  logic        req_ready [2];
  logic [31:0] addr      [2];
  logic [31:0] data      [2];
  logic [1:0]  size      [2];
  logic        mem_valid [2];
  logic        mem_ready [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [3:0]  mem_bmask [2];
  logic        err       [2];
  bit          err_exp   [2];

  int checks = 0;
  int errors = 0;

  mem_beat_t q0[$];
  mem_beat_t q1[$];

  always #5 clk = ~clk;

  store_align #(.SPLIT_EN(1'b0)) u_nosplit (
    .i_clk(clk), .i_reset(rst),
    .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
    .i_addr(addr[0]), .i_data(data[0]), .i_size(size[0]),
    .o_mem_valid(mem_valid[0]), .i_mem_ready(mem_ready[0]),
    .o_mem_addr(mem_addr[0]), .o_mem_wdata(mem_wdata[0]),
    .o_mem_bmask(mem_bmask[0]), .o_err(err[0])
  );

  store_align #(.SPLIT_EN(1'b1)) u_split (
    .i_clk(clk), .i_reset(rst),
    .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
    .i_addr(addr[1]), .i_data(data[1]), .i_size(size[1]),
    .o_mem_valid(mem_valid[1]), .i_mem_ready(mem_ready[1]),
    .o_mem_addr(mem_addr[1]), .o_mem_wdata(mem_wdata[1]),
    .o_mem_bmask(mem_bmask[1]), .o_err(err[1])
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int qsize(int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic mem_beat_t qhead(int k);
    return (k == 0) ? q0[0] : q1[0];
  endfunction

  function automatic void qpop(int k);
    if (k == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endfunction

  function automatic void qpush(int k, mem_beat_t b);
    if (k == 0) q0.push_back(b);
    else        q1.push_back(b);
  endfunction

  // Walk every stored byte to its absolute address; group bytes by word.
  function automatic void model_req(input int k, input logic [31:0] a,
                                    input logic [31:0] d, input logic [1:0] sz,
                                    output int nb, output mem_beat_t b0,
                                    output mem_beat_t b1, output bit rej);
    mem_beat_t bl[2];
    int n;
    int cnt;
    n   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    cnt = 0;
    bl[0] = '0;
    bl[1] = '0;
    for (int i = 0; i < n; i++) begin
      logic [31:0] ba;
      logic [31:0] wa;
      int lane;
      int j;
      ba   = a + 32'(i);
      wa   = ba & ~32'h3;
      lane = int'(ba[1:0]);
      j    = -1;
      for (int m = 0; m < cnt; m++) if (bl[m].addr == wa) j = m;
      if (j < 0) begin
        j = cnt;
        bl[j].addr = wa;
        cnt++;
      end
      bl[j].bmask[lane]         = 1'b1;
      bl[j].wdata[8*lane +: 8]  = d[8*i +: 8];
    end
    rej = (cnt == 2) && (k == 0);
    nb  = rej ? 0 : cnt;
    b0  = bl[0];
    b1  = bl[1];
  endfunction

  task automatic send(input int k, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] sz, output mem_beat_t b0,
                      output mem_beat_t b1, output int nb, output int waited);
    bit rej;
    req_valid[k] = 1'b1;
    addr[k]      = a;
    data[k]      = d;
    size[k]      = sz;
    waited       = 0;
    while (req_ready[k] !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 20) chk("accept_timeout", 32'(req_ready[k]), 32'd1);
    model_req(k, a, d, sz, nb, b0, b1, rej);
    @(posedge clk);
    if (nb > 0) qpush(k, b0);
    if (nb > 1) qpush(k, b1);
    err_exp[k] = rej;
    #1;
    req_valid[k] = 1'b0;
    if (rej) begin
      @(posedge clk);
      err_exp[k] = 1'b0;
      #1;
    end
  endtask

  task automatic drain(input int k);
    int n;
    n = 0;
    while (qsize(k) != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) chk("drain_timeout", 32'(qsize(k)), 32'd0);
  endtask

  task automatic pin(string name, mem_beat_t b, logic [31:0] a, logic [3:0] m,
                     logic [31:0] w);
    chk({name, "_addr"},  b.addr,        a);
    chk({name, "_bmask"}, 32'(b.bmask),  32'(m));
    chk({name, "_wdata"}, b.wdata,       w);
  endtask

  // Per-cycle comparison of both instances against the model queues.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        chk("rst_valid", 32'(mem_valid[k]), 32'd0);
        chk("rst_ready", 32'(req_ready[k]), 32'd1);
        chk("rst_err",   32'(err[k]),       32'd0);
        chk("rst_addr",  mem_addr[k],       32'd0);
        chk("rst_wdata", mem_wdata[k],      32'd0);
        chk("rst_bmask", 32'(mem_bmask[k]), 32'd0);
      end else begin
        chk("req_ready", 32'(req_ready[k]), 32'(qsize(k) == 0));
        chk("mem_valid", 32'(mem_valid[k]), 32'(qsize(k) != 0));
        chk("err",       32'(err[k]),       32'(err_exp[k]));
        if (mem_valid[k] === 1'b1 && qsize(k) != 0) begin
          mem_beat_t h;
          h = qhead(k);
          chk("beat_addr",  mem_addr[k],       h.addr);
          chk("beat_wdata", mem_wdata[k],      h.wdata);
          chk("beat_bmask", 32'(mem_bmask[k]), 32'(h.bmask));
          if (mem_ready[k] === 1'b1) qpop(k);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    mem_beat_t b0, b1;
    int nb, w;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0;
      addr[k]      = '0;
      data[k]      = '0;
      size[k]      = '0;
      mem_ready[k] = 1'b1;
      err_exp[k]   = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single byte in the top lane.
    send(1, 32'h0000_1003, 32'h0000_00AB, 2'b00, b0, b1, nb, w);
    chk("byte_nbeats", 32'(nb), 32'd1);
    pin("byte_b0", b0, 32'h0000_1000, 4'b1000, 32'hAB00_0000);
    drain(1);

    // Halfword straddling a word boundary.
    send(1, 32'h0000_2003, 32'h0000_BEEF, 2'b01, b0, b1, nb, w);
    chk("half_split_nbeats", 32'(nb), 32'd2);
    pin("half_split_b0", b0, 32'h0000_2000, 4'b1000, 32'hEF00_0000);
    pin("half_split_b1", b1, 32'h0000_2004, 4'b0001, 32'h0000_00BE);
    drain(1);

    // Word split across the top of the address space.
    send(1, 32'hFFFF_FFFE, 32'h1122_3344, 2'b10, b0, b1, nb, w);
    pin("wrap_b0", b0, 32'hFFFF_FFFC, 4'b1100, 32'h3344_0000);
    pin("wrap_b1", b1, 32'h0000_0000, 4'b0011, 32'h0000_1122);
    drain(1);

    // Aligned halfword with junk in the upper data bits.
    send(1, 32'h0000_3002, 32'hDEAD_CAFE, 2'b01, b0, b1, nb, w);
    pin("half_hi", b0, 32'h0000_3000, 4'b1100, 32'hCAFE_0000);
    drain(1);

    // Reserved size acts as a word; offset 1 splits.
    send(1, 32'h0000_4001, 32'hA1B2_C3D4, 2'b11, b0, b1, nb, w);
    pin("rsvd_b0", b0, 32'h0000_4000, 4'b1110, 32'hB2C3_D400);
    pin("rsvd_b1", b1, 32'h0000_4004, 4'b0001, 32'h0000_00A1);
    drain(1);

    // Halfword at offset 1 stays in one word.
    send(1, 32'h0000_5001, 32'h0000_1234, 2'b01, b0, b1, nb, w);
    chk("half_mid_nbeats", 32'(nb), 32'd1);
    drain(1);

    // Backpressure for five cycles on the first beat.
    mem_ready[1] = 1'b0;
    send(1, 32'h0000_6002, 32'h5566_7788, 2'b10, b0, b1, nb, w);
    repeat (5) @(posedge clk);
    #1 mem_ready[1] = 1'b1;
    drain(1);
    // Backpressure in the second beat as well.
    send(1, 32'h0000_6103, 32'h0000_9911, 2'b01, b0, b1, nb, w);
    @(posedge clk); #1 mem_ready[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1 mem_ready[1] = 1'b1;
    drain(1);

    // Non-splitting instance: aligned work still goes through.
    send(0, 32'h0000_7002, 32'h0000_0042, 2'b00, b0, b1, nb, w);
    pin("ns_byte", b0, 32'h0000_7000, 4'b0100, 32'h0042_0000);
    drain(0);
    // Misaligned word and halfword are rejected.
    send(0, 32'h0000_0001, 32'hCAFE_F00D, 2'b10, b0, b1, nb, w);
    chk("ns_word_nbeats", 32'(nb), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    send(0, 32'h0000_0103, 32'h0000_ABCD, 2'b01, b0, b1, nb, w);
    chk("ns_half_nbeats", 32'(nb), 32'd0);
    send(0, 32'h0000_0200, 32'h0102_0304, 2'b10, b0, b1, nb, w);
    pin("ns_word", b0, 32'h0000_0200, 4'b1111, 32'h0102_0304);
    drain(0);

    // Reset while the second beat of a split is presented.
    send(1, 32'h0000_8002, 32'hAABB_CCDD, 2'b10, b0, b1, nb, w);
    @(posedge clk); #1;
    chk("pre_reset_beat1_addr", mem_addr[1], 32'h0000_8004);
    rst = 1'b1;
    q0.delete();
    q1.delete();
    #1;
    chk("reset_immediate_valid", 32'(mem_valid[1]), 32'd0);
    chk("reset_immediate_ready", 32'(req_ready[1]), 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // First request taken on the first edge after reset release.
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    send(1, 32'h0000_9000, 32'h0000_0077, 2'b00, b0, b1, nb, w);
    chk("first_accept_wait", 32'(w), 32'd0);
    drain(1);

    repeat (3) @(posedge clk);
    #1;
    chk("final_q0_empty", 32'(q0.size()), 32'd0);
    chk("final_q1_empty", 32'(q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
